// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute-side signal bundle of the branch predictor controller.
// Signal suffixes are relative to the controller: _i are driven into it,
// _o are driven by it.
interface branch_predict_ctrl_if;
  // fetch side
  logic        stall_i;
  logic [31:0] pc_if_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [31:0] next_pc_o;
  // execute side
  logic        ex_valid_i;
  logic [31:0] inst_ex_i;
  logic [31:0] pc_ex_i;
  logic        taken_ex_i;
  logic [31:0] target_ex_i;
  logic        pred_taken_ex_i;
  logic [31:0] pred_target_ex_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  // performance counters
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  // pipeline side that drives the controller
  modport master (
    output stall_i, pc_if_i, ex_valid_i, inst_ex_i, pc_ex_i, taken_ex_i,
           target_ex_i, pred_taken_ex_i, pred_target_ex_i,
    input  pred_taken_o, pred_target_o, next_pc_o, redirect_o, redirect_pc_o,
           flush_o, branch_cnt_o, mispred_cnt_o
  );

  // the controller itself
  modport slave (
    input  stall_i, pc_if_i, ex_valid_i, inst_ex_i, pc_ex_i, taken_ex_i,
           target_ex_i, pred_taken_ex_i, pred_target_ex_i,
    output pred_taken_o, pred_target_o, next_pc_o, redirect_o, redirect_pc_o,
           flush_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Fetch-side BTB predictor with 2-bit counters, plus EX-stage misprediction
// detection, redirect/flush generation, table training and perf counters.
module branch_predict_ctrl #(
  parameter int IDX_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  branch_predict_ctrl_if.slave  bus
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [31:0]       target;
    logic [1:0]        ctr;
    logic              jmp;
  } btb_ent_t;

  localparam btb_ent_t RST_ENT = '{valid: 1'b0, tag: '0, target: '0,
                                   ctr: 2'b01, jmp: 1'b0};

  typedef enum logic {IDLE, RECOVER} state_t;

  btb_ent_t    btb_q [N];
  state_t      state_q, state_d;
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // ---------------- IF lookup (reads pre-edge table contents) ------------
  logic [IDX_W-1:0] if_idx;
  btb_ent_t         if_ent;
  logic             if_hit, pred_taken;
  logic [31:0]      pred_target;

  assign if_idx      = bus.pc_if_i[IDX_W+1:2];
  assign if_ent      = btb_q[if_idx];
  assign if_hit      = if_ent.valid && (if_ent.tag == bus.pc_if_i[31:IDX_W+2]);
  assign pred_taken  = if_hit && (if_ent.jmp || if_ent.ctr[1]);
  assign pred_target = pred_taken ? if_ent.target : bus.pc_if_i + 32'd4;

  // ---------------- EX resolution ----------------------------------------
  logic [6:0]       opcode;
  logic             is_br, is_ct, resolve, mispred;
  logic [31:0]      pc_ex_p4;

  assign opcode   = bus.inst_ex_i[6:0];
  assign is_br    = (opcode == OP_BRANCH);
  assign is_ct    = is_br || (opcode == OP_JAL) || (opcode == OP_JALR);
  // wrong-path instructions during RECOVER never resolve
  assign resolve  = bus.ex_valid_i && is_ct && !bus.stall_i && (state_q == IDLE);
  assign mispred  = resolve &&
                    ((bus.taken_ex_i != bus.pred_taken_ex_i) ||
                     (bus.taken_ex_i && (bus.target_ex_i != bus.pred_target_ex_i)));
  assign pc_ex_p4 = bus.pc_ex_i + 32'd4;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and redirect/flush outputs
  logic        redirect;
  logic [31:0] redirect_pc;
  always_comb begin
    state_d     = state_q;
    redirect    = 1'b0;
    redirect_pc = pc_ex_p4;
    case (state_q)
      IDLE: begin
        if (mispred) begin
          redirect    = 1'b1;
          redirect_pc = bus.taken_ex_i ? bus.target_ex_i : pc_ex_p4;
          state_d     = RECOVER;
        end
      end
      RECOVER: begin
        if (!bus.stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- training ---------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_ent_t         ex_ent, upd_ent;
  logic             ex_hit, upd_en;

  assign ex_idx = bus.pc_ex_i[IDX_W+1:2];
  assign ex_tag = bus.pc_ex_i[31:IDX_W+2];
  assign ex_ent = btb_q[ex_idx];
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  // compute the updated entry for the resolving instruction
  always_comb begin
    upd_en  = 1'b0;
    upd_ent = ex_ent;
    if (resolve) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (bus.taken_ex_i) begin
          if (ex_ent.ctr != 2'b11) upd_ent.ctr = ex_ent.ctr + 2'd1;
          upd_ent.target = bus.target_ex_i;
          upd_ent.jmp    = !is_br;
        end else if (ex_ent.ctr != 2'b00) begin
          upd_ent.ctr = ex_ent.ctr - 2'd1;
        end
      end else if (bus.taken_ex_i) begin
        upd_en         = 1'b1;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = ex_tag;
        upd_ent.target = bus.target_ex_i;
        upd_ent.ctr    = is_br ? 2'b10 : 2'b11;
        upd_ent.jmp    = !is_br;
      end
    end
  end

  // BTB storage; reset empties the whole table at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) btb_q[i] <= RST_ENT;
    end else if (upd_en) begin
      btb_q[ex_idx] <= upd_ent;
    end
  end

  // performance counters, free-running wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_target;
  assign bus.next_pc_o     = redirect ? redirect_pc : pred_target;
  assign bus.redirect_o    = redirect;
  assign bus.flush_o       = redirect;
  assign bus.redirect_pc_o = redirect_pc;
  assign bus.branch_cnt_o  = branch_cnt_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: BTB allocate/train, mispredict
// redirect, RECOVER squash, stall hold and asynchronous reset.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JALR = 32'h0000_0067;

  branch_predict_ctrl_if bus();

  branch_predict_ctrl #(.IDX_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ex_set(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid_i       = v;
    bus.inst_ex_i        = inst;
    bus.pc_ex_i          = pc;
    bus.taken_ex_i       = tk;
    bus.target_ex_i      = tgt;
    bus.pred_taken_ex_i  = ptk;
    bus.pred_target_ex_i = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall_i = 1'b0;
    bus.pc_if_i = 32'h100;
    ex_idle();
    #1;
    // reset state
    chk("rst_pred_taken", {31'b0, bus.pred_taken_o}, 32'd0);
    chk("rst_next_pc", bus.next_pc_o, 32'h104);
    chk("rst_redirect", {31'b0, bus.redirect_o}, 32'd0);
    chk("rst_branch_cnt", bus.branch_cnt_o, 32'd0);
    chk("rst_mispred_cnt", bus.mispred_cnt_o, 32'd0);
    step();
    rst = 1'b0;
    step();

    // BEQ @0x40 taken to 0x80, predicted not taken, same-index lookup in IF
    bus.pc_if_i = 32'h40;
    ex_set(1'b1, BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    chk("beq1_nobypass", {31'b0, bus.pred_taken_o}, 32'd0);
    chk("beq1_redirect", {31'b0, bus.redirect_o}, 32'd1);
    chk("beq1_flush", {31'b0, bus.flush_o}, 32'd1);
    chk("beq1_redir_pc", bus.redirect_pc_o, 32'h80);
    chk("beq1_next_pc", bus.next_pc_o, 32'h80);
    step();
    ex_idle();
    #1;
    chk("beq1_mispred_cnt", bus.mispred_cnt_o, 32'd1);
    chk("beq1_branch_cnt", bus.branch_cnt_o, 32'd1);
    chk("beq1_lkp_taken", {31'b0, bus.pred_taken_o}, 32'd1);
    chk("beq1_lkp_target", bus.pred_target_o, 32'h80);
    step(); // RECOVER -> IDLE

    // same BEQ not taken: ctr 10 -> 01 (mispredict)
    ex_set(1'b1, BEQ, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("nt1_redirect", {31'b0, bus.redirect_o}, 32'd1);
    chk("nt1_redir_pc", bus.redirect_pc_o, 32'h44);
    step();
    ex_idle();
    step(); // RECOVER -> IDLE
    #1;
    chk("nt1_lkp_taken", {31'b0, bus.pred_taken_o}, 32'd0);
    // ctr 01 -> 00, predicted correctly
    ex_set(1'b1, BEQ, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    #1;
    chk("nt2_redirect", {31'b0, bus.redirect_o}, 32'd0);
    step();
    // ctr 00 stays 00
    #1;
    chk("nt3_redirect", {31'b0, bus.redirect_o}, 32'd0);
    step();
    ex_idle();
    #1;
    chk("nt_branch_cnt", bus.branch_cnt_o, 32'd4);
    chk("nt_mispred_cnt", bus.mispred_cnt_o, 32'd2);
    chk("nt_lkp_taken", {31'b0, bus.pred_taken_o}, 32'd0);
    chk("nt_lkp_target", bus.pred_target_o, 32'h44);

    // JALR @0x20: allocate to 0x200, then retarget to 0x300
    ex_set(1'b1, JALR, 32'h20, 1'b1, 32'h200, 1'b0, 32'h24);
    #1;
    chk("jalr0_redir_pc", bus.redirect_pc_o, 32'h200);
    step();
    ex_idle();
    bus.pc_if_i = 32'h20;
    #1;
    chk("jalr0_lkp_taken", {31'b0, bus.pred_taken_o}, 32'd1);
    chk("jalr0_lkp_target", bus.pred_target_o, 32'h200);
    step(); // RECOVER -> IDLE
    ex_set(1'b1, JALR, 32'h20, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    chk("jalr1_redirect", {31'b0, bus.redirect_o}, 32'd1);
    chk("jalr1_redir_pc", bus.redirect_pc_o, 32'h300);
    step();

    // RECOVER: wrong-path BEQ @0x60 must be ignored
    ex_set(1'b1, BEQ, 32'h60, 1'b1, 32'hC0, 1'b0, 32'h64);
    #1;
    chk("rec_redirect", {31'b0, bus.redirect_o}, 32'd0);
    chk("rec_flush", {31'b0, bus.flush_o}, 32'd0);
    chk("jalr1_lkp_target", bus.pred_target_o, 32'h300);
    step();
    bus.pc_if_i = 32'h60;
    #1;
    chk("rec_branch_cnt", bus.branch_cnt_o, 32'd6);
    chk("rec_mispred_cnt", bus.mispred_cnt_o, 32'd4);
    chk("rec_no_write", {31'b0, bus.pred_taken_o}, 32'd0);
    // now IDLE: the same BEQ resolves normally
    chk("idle_redirect", {31'b0, bus.redirect_o}, 32'd1);
    chk("idle_redir_pc", bus.redirect_pc_o, 32'hC0);
    step();
    ex_idle();
    step(); // RECOVER -> IDLE
    #1;
    chk("idle_branch_cnt", bus.branch_cnt_o, 32'd7);
    chk("beq60_lkp_taken", {31'b0, bus.pred_taken_o}, 32'd1);

    // stall with mispredicting BEQ @0x60 (not taken, predicted taken)
    bus.stall_i = 1'b1;
    ex_set(1'b1, BEQ, 32'h60, 1'b0, 32'hC0, 1'b1, 32'hC0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_redirect", {31'b0, bus.redirect_o}, 32'd0);
      chk("stall_next_pc", bus.next_pc_o, 32'hC0);
      step();
      chk("stall_branch_cnt", bus.branch_cnt_o, 32'd7);
      chk("stall_mispred_cnt", bus.mispred_cnt_o, 32'd5);
    end
    bus.stall_i = 1'b0;
    #1;
    chk("unstall_redirect", {31'b0, bus.redirect_o}, 32'd1);
    chk("unstall_redir_pc", bus.redirect_pc_o, 32'h64);
    step(); // now in RECOVER
    chk("unstall_mispred_cnt", bus.mispred_cnt_o, 32'd6);

    // asynchronous reset in RECOVER
    ex_idle();
    bus.pc_if_i = 32'h20;
    rst = 1'b1;
    #1;
    chk("arst_branch_cnt", bus.branch_cnt_o, 32'd0);
    chk("arst_mispred_cnt", bus.mispred_cnt_o, 32'd0);
    chk("arst_pred_taken", {31'b0, bus.pred_taken_o}, 32'd0);
    chk("arst_next_pc", bus.next_pc_o, 32'h24);
    step();
    rst = 1'b0;
    // back in IDLE: a mispredict must redirect straight away
    ex_set(1'b1, BEQ, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    chk("arst_idle_redirect", {31'b0, bus.redirect_o}, 32'd1);
    step();
    ex_idle();
    #1;
    chk("arst_post_mispred", bus.mispred_cnt_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Fetch-side branch predictor and misprediction-recovery controller for the 5-stage RV32I pipeline.
- IF: looks up a direct-mapped BTB with a 2-bit counter per entry and drives the next fetch PC.
- EX: compares the resolved outcome (taken/target from the branch-taken logic) with the prediction carried down the pipe, then redirects fetch and flushes IF/ID and ID/EX on mismatch.
- Trains the table and keeps performance counters.

Parameters:
IDX_W, 6, BTB index width; 2^IDX_W entries, index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
stall_i  input  1  pipeline stall; freezes resolution and training
pc_if_i  input  32  current fetch PC
pred_taken_o  output  1  IF prediction: taken
pred_target_o  output  32  IF predicted next PC (target if taken, else pc_if_i+4)
next_pc_o  output  32  PC register D-input
ex_valid_i  input  1  EX stage holds a valid instruction
inst_ex_i  input  32  EX instruction (opcode [6:0])
pc_ex_i  input  32  EX instruction PC
taken_ex_i  input  1  resolved taken (branch condition met, or JAL/JALR)
target_ex_i  input  32  resolved target (ALU result)
pred_taken_ex_i  input  1  prediction carried from IF for this instruction
pred_target_ex_i  input  32  predicted next PC carried from IF
redirect_o  output  1  mispredict: fetch from redirect_pc_o next
redirect_pc_o  output  32  correct next PC
flush_o  output  1  squash IF/ID and ID/EX this edge
branch_cnt_o  output  32  resolved control-transfer count
mispred_cnt_o  output  32  misprediction count

Behaviour:
- Reset (async, rst_i=1): all entries valid=0, ctr=2'b01, jmp=0; state=IDLE; both counters=0. Outputs are combinational: with the table empty, pred_taken_o=0, pred_target_o=pc_if_i+4, redirect_o=0, flush_o=0. Reset asserted mid-operation aborts any RECOVER and clears the table the same instant.
- Entry fields: valid, tag[31-IDX_W-2:0], target[31:0], ctr[1:0], jmp.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken_o = hit & (jmp | ctr[1]).
  - pred_target_o = pred_taken_o ? target : pc_if_i+4.
  - next_pc_o = redirect_o ? redirect_pc_o : pred_target_o.
- Control transfer in EX: opcode is 1100011 (branch), 1101111 (JAL) or 1100111 (JALR). resolve = ex_valid_i & control transfer & ~stall_i & state==IDLE.
- Mispredict = resolve & ((taken_ex_i != pred_taken_ex_i) | (taken_ex_i & target_ex_i != pred_target_ex_i)).
- On mispredict: redirect_o = flush_o = 1; redirect_pc_o = taken_ex_i ? target_ex_i : pc_ex_i+4. Otherwise redirect_o = flush_o = 0, and redirect_pc_o = pc_ex_i+4 (don't-care).
- FSM:
  - IDLE -> RECOVER on mispredict.
  - RECOVER -> IDLE unconditionally next cycle unless stall_i=1 (then hold RECOVER).
  - In RECOVER, resolve=0: the EX instruction is wrong-path and never trains or redirects.
- Training (clock edge when resolve=1), entry at index of pc_ex_i:
  - Hit & taken: ctr saturating +1 (max 3); target <- target_ex_i; jmp <- opcode!=branch.
  - Hit & not taken: ctr saturating -1 (min 0).
  - Miss & taken: allocate/overwrite with valid=1, new tag, target_ex_i; ctr=2'b10 for a branch, 2'b11 for a jump; jmp as above.
  - Miss & not taken: no change.
- Counters:
  - branch_cnt_o +1 per resolve.
  - mispred_cnt_o +1 per mispredict.
  - Both wrap 0xFFFFFFFF -> 0.
- Simultaneous IF lookup and EX update of the same index: lookup returns pre-edge contents (no bypass).
- stall_i=1: no training, no counter change, redirect_o/flush_o forced 0. The EX instruction resolves when the stall drops.

Test Plan:
- Reset, pc_if_i=0x100 -> pred_taken_o=0, next_pc_o=0x104; both counters 0.
- BEQ at 0x40, taken to 0x80, pred_taken_ex_i=0 -> redirect_o=flush_o=1, redirect_pc_o=0x80, mispred_cnt_o=1; next cycle pc_if_i=0x40 -> pred_taken_o=1, pred_target_o=0x80.
- Same BEQ not taken 3 times, predictions fed back -> ctr 10->01->00->00 (first resolve mispredicts, redirect_pc_o=0x44; later ones don't); lookup of 0x40 then gives pred_taken_o=0.
- JALR at 0x20, predicted taken to 0x200, resolved to 0x300 -> target mismatch, redirect_pc_o=0x300; entry target updated to 0x300.
- Mispredict followed next cycle by a valid branch in EX with wrong prediction (RECOVER) -> redirect_o=0, counters unchanged, no table write; next IDLE cycle resolves normally.
- stall_i=1 with mispredicting branch in EX for 2 cycles -> no redirect, counters unchanged; redirect once stall_i drops. Assert rst_i during RECOVER -> state IDLE, table empty, counters 0 immediately.
